// File: rtl/part1_sequencer_pkg.sv
// Shared types and constants for the part1 solver sequencer.
package part1_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND     = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_CLEAR    = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_DP     = 2'd1,
    ERR_ACK_TO = 2'd2,
    ERR_RES_TO = 2'd3
  } seq_err_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam int         TMR_W    = 32;

  // States in which the solver handshake is in flight and supervised.
  function automatic logic is_supervised(input seq_state_t st);
    return (st == ST_SEND) || (st == ST_WAIT_RES) || (st == ST_RELEASE);
  endfunction

endpackage

// File: rtl/part1_sequencer_timer.sv
// Loadable timeout counter; expired flags the last cycle before the limit is reached.
module seq_timer
  import part1_seq_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + {{(W-1){1'b0}}, 1'b1};
  assign expired   = enable && (w_cnt_inc >= limit);

  // Cycle counter, restarted on every state change of the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_cnt_inc;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/part1_sequencer.sv
// Bridges a ready/valid byte stream onto the part1 solver's four-phase handshake
// and collects per-line results, with ack/result timeouts and error recovery.
module part1_sequencer
  import part1_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT    = 1024,
  parameter int RESULT_TIMEOUT = 100,
  parameter int LINE_CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [7:0]            dp_data,
  output logic                  dp_valid,
  input  logic                  dp_ack,
  input  logic [31:0]           dp_result,
  input  logic                  dp_result_ready,
  input  logic                  dp_error,
  output logic                  dp_error_clear,
  output logic [31:0]           final_result,
  output logic [LINE_CNT_W-1:0] lines_done,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  seq_state_t            r_state;
  seq_state_t            w_state_next;
  logic [7:0]            r_dp_data;
  logic                  r_last;
  logic                  r_dp_valid;
  logic                  r_dp_error_clear;
  logic [31:0]           r_final_result;
  logic [LINE_CNT_W-1:0] r_lines_done;
  logic                  r_done;
  logic                  r_err;
  seq_err_t              r_err_code;

  logic                  w_accept;
  logic                  w_latch;
  logic                  w_err_set;
  seq_err_t              w_err_code;
  logic                  w_expired;
  logic                  w_tmr_clear;
  logic                  w_tmr_en;
  logic [TMR_W-1:0]      w_tmr_limit;
  logic                  w_is_lf;

  assign s_ready        = (r_state == ST_IDLE);
  assign dp_data        = r_dp_data;
  assign dp_valid       = r_dp_valid;
  assign dp_error_clear = r_dp_error_clear;
  assign final_result   = r_final_result;
  assign lines_done     = r_lines_done;
  assign done           = r_done;
  assign err            = r_err;
  assign err_code       = r_err_code;

  assign w_is_lf     = (r_dp_data == ASCII_LF);
  assign w_tmr_clear = (w_state_next != r_state);
  assign w_tmr_en    = is_supervised(r_state);
  assign w_tmr_limit = (r_state == ST_WAIT_RES) ? TMR_W'(RESULT_TIMEOUT) : TMR_W'(ACK_TIMEOUT);

  seq_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_tmr_clear),
    .enable  (w_tmr_en),
    .limit   (w_tmr_limit),
    .expired (w_expired)
  );

  // Next-state decode; solver error outranks ack, result and timeout.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_latch      = 1'b0;
    w_err_set    = 1'b0;
    w_err_code   = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (s_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_SEND;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (dp_error) begin
          w_state_next = ST_CLEAR;
        end else if (dp_ack) begin
          if (w_is_lf && dp_result_ready) begin
            w_latch      = 1'b1;
            w_state_next = ST_RELEASE;
          end else if (w_is_lf) begin
            w_state_next = ST_WAIT_RES;
          end else begin
            w_state_next = ST_RELEASE;
          end
        end else if (w_expired) begin
          w_err_set    = 1'b1;
          w_err_code   = ERR_ACK_TO;
          w_state_next = ST_ERROR;
        end else begin
          w_state_next = ST_SEND;
        end
      end
      ST_WAIT_RES: begin
        if (dp_error) begin
          w_state_next = ST_CLEAR;
        end else if (dp_result_ready) begin
          w_latch      = 1'b1;
          w_state_next = ST_RELEASE;
        end else if (w_expired) begin
          w_err_set    = 1'b1;
          w_err_code   = ERR_RES_TO;
          w_state_next = ST_ERROR;
        end else begin
          w_state_next = ST_WAIT_RES;
        end
      end
      ST_RELEASE: begin
        if (dp_error) begin
          w_state_next = ST_CLEAR;
        end else if (!dp_ack) begin
          w_state_next = r_last ? ST_DONE : ST_IDLE;
        end else if (w_expired) begin
          w_err_set    = 1'b1;
          w_err_code   = ERR_ACK_TO;
          w_state_next = ST_ERROR;
        end else begin
          w_state_next = ST_RELEASE;
        end
      end
      ST_CLEAR: begin
        w_err_set    = 1'b1;
        w_err_code   = ERR_DP;
        w_state_next = ST_ERROR;
      end
      ST_DONE:  w_state_next = ST_DONE;
      ST_ERROR: w_state_next = ST_ERROR;
      default:  w_state_next = ST_ERROR;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Byte holding register and its end-of-input marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_data <= 8'h00;
      r_last    <= 1'b0;
    end else if (w_accept) begin
      r_dp_data <= s_data;
      r_last    <= s_last;
    end else begin
      r_dp_data <= r_dp_data;
      r_last    <= r_last;
    end
  end

  // Handshake outputs follow the state being entered so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_valid       <= 1'b0;
      r_dp_error_clear <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_dp_valid       <= (w_state_next == ST_SEND) || (w_state_next == ST_WAIT_RES);
      r_dp_error_clear <= (w_state_next == ST_CLEAR);
      r_done           <= r_done || (w_state_next == ST_DONE);
    end
  end

  // Per-line result capture; the line counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_final_result <= 32'h0000_0000;
      r_lines_done   <= '0;
    end else if (w_latch) begin
      r_final_result <= dp_result;
      r_lines_done   <= r_lines_done + LINE_CNT_W'(1);
    end else begin
      r_final_result <= r_final_result;
      r_lines_done   <= r_lines_done;
    end
  end

  // Sticky error flag; the first cause recorded is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else if (w_err_set && !r_err) begin
      r_err      <= 1'b1;
      r_err_code <= w_err_code;
    end else begin
      r_err      <= r_err;
      r_err_code <= r_err_code;
    end
  end

endmodule

// File: tb/tb_part1_sequencer.sv
// Directed + randomized bench for part1_sequencer with a behavioural solver responder.
module tb_part1_sequencer;
  localparam int ACK_TO = 20;
  localparam int RES_TO = 10;
  localparam int LCW    = 16;
  localparam logic [7:0] LF = 8'h0A;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     s_data = 8'h00;
  logic           s_valid = 1'b0;
  logic           s_last = 1'b0;
  logic           s_ready;
  logic [7:0]     dp_data;
  logic           dp_valid;
  logic           dp_ack = 1'b0;
  logic [31:0]    dp_result = 32'h0;
  logic           dp_result_ready = 1'b0;
  logic           dp_error = 1'b0;
  logic           dp_error_clear;
  logic [31:0]    final_result;
  logic [LCW-1:0] lines_done;
  logic           done;
  logic           err;
  logic [1:0]     err_code;

  always #5 clk = ~clk;

  part1_sequencer #(.ACK_TIMEOUT(ACK_TO), .RESULT_TIMEOUT(RES_TO), .LINE_CNT_W(LCW)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .dp_data(dp_data), .dp_valid(dp_valid), .dp_ack(dp_ack),
    .dp_result(dp_result), .dp_result_ready(dp_result_ready), .dp_error(dp_error),
    .dp_error_clear(dp_error_clear), .final_result(final_result), .lines_done(lines_done),
    .done(done), .err(err), .err_code(err_code)
  );

  int checks = 0;
  int errors = 0;
  // Solver model knobs: mode 0 normal, 1 never ack, 2 never result, 3 data_error in result wait.
  int mode = 0, ack_dly = 2, res_dly = 3, rel_dly = 0;
  logic [31:0] res_q[$];
  int cyc = 0, t_valid = 0, t_ack = 0, t_err = 0, viol = 0, clr_cnt = 0;
  logic m_pv = 1'b0, m_pa = 1'b0, m_pe = 1'b0;
  int sol_ph = 0, sol_cnt = 0;
  bit sol_edone = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (dp_valid && !m_pv) begin
        if (dp_ack) viol++;
        t_valid = cyc;
      end
      if (dp_ack && !m_pa) t_ack = cyc;
      if (err && !m_pe) t_err = cyc;
      if (dp_error_clear) clr_cnt++;
      m_pv = dp_valid;
      m_pa = dp_ack;
      m_pe = err;
    end
  end

  initial begin : solver
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sol_ph = 0; sol_cnt = 0; sol_edone = 1'b0;
        dp_ack = 1'b0; dp_result_ready = 1'b0; dp_error = 1'b0;
      end else begin
        if (dp_error_clear) dp_error = 1'b0;
        if (sol_ph == 0 && dp_valid) begin
          sol_ph = 1; sol_cnt = 0;
        end
        if (sol_ph == 1) begin
          if (mode != 1) begin
            if (sol_cnt >= ack_dly) begin
              dp_ack = 1'b1; sol_cnt = 0;
              if (dp_data == LF && mode == 0 && res_dly == 0) begin
                dp_result = (res_q.size() > 0) ? res_q.pop_front() : 32'h0;
                dp_result_ready = 1'b1; sol_ph = 3;
              end else if (dp_data == LF) begin
                sol_ph = 2;
              end else begin
                sol_ph = 3;
              end
            end else begin
              sol_cnt++;
            end
          end
        end else if (sol_ph == 2) begin
          sol_cnt++;
          if (mode == 0 && sol_cnt >= res_dly) begin
            dp_result = (res_q.size() > 0) ? res_q.pop_front() : 32'h0;
            dp_result_ready = 1'b1; sol_ph = 3; sol_cnt = 0;
          end else if (mode == 3 && sol_cnt == 2 && !sol_edone) begin
            dp_error = 1'b1; sol_edone = 1'b1;
          end
        end else if (sol_ph == 3) begin
          if (!dp_valid) begin
            dp_result_ready = 1'b0;
            if (sol_cnt >= rel_dly) begin
              dp_ack = 1'b0; sol_ph = 0; sol_cnt = 0;
            end else begin
              sol_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    res_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_to"}, 32'(n < 2000), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    wait_ready("send");
    s_valid = 1'b1; s_data = b; s_last = last;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_at_end);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last_at_end && (i == s.len() - 1));
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || err) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_end_to"}, 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    logic [7:0] bq[$];
    logic [31:0] exp_final, r;
    int exp_lines, base, sr_any;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_dp_valid", 32'(dp_valid), 32'd0);
    chk("rst_dp_data", 32'(dp_data), 32'd0);
    chk("rst_final", final_result, 32'd0);
    chk("rst_lines", 32'(lines_done), 32'd0);
    chk("rst_done_err", {done, err, err_code}, 32'd0);

    // One line "987\n" with result 98
    mode = 0; ack_dly = 2; res_dly = 3; rel_dly = 0;
    res_q.push_back(32'd98);
    send_str("987\n", 1'b1);
    wait_end("t1");
    chk("t1_final", final_result, 32'd98);
    chk("t1_lines", 32'(lines_done), 32'd1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_err", 32'(err), 32'd0);

    // Three lines 98, 89, 92
    do_reset();
    viol = 0; ack_dly = 1; res_dly = 0; rel_dly = 2;
    res_q.push_back(32'd98); res_q.push_back(32'd89); res_q.push_back(32'd92);
    send_str("12\n", 1'b0);
    send_str("345\n", 1'b0);
    send_str("6\n", 1'b1);
    wait_end("t2");
    chk("t2_final", final_result, 32'd92);
    chk("t2_lines", 32'(lines_done), 32'd3);
    chk("t2_done", 32'(done), 32'd1);

    // Final byte without LF and no line ever: final stays 0
    do_reset();
    send_str("5", 1'b1);
    wait_end("t2b");
    chk("t2b_done", 32'(done), 32'd1);
    chk("t2b_final", final_result, 32'd0);
    chk("t2b_lines", 32'(lines_done), 32'd0);

    // Randomized streams checked against a line-count/last-result model
    for (int it = 0; it < 4; it++) begin
      do_reset();
      bq.delete(); exp_final = 32'h0; exp_lines = 0;
      for (int ln = 0; ln < int'($urandom_range(2, 5)); ln++) begin
        for (int d = 0; d < int'($urandom_range(1, 3)); d++) bq.push_back(8'h30 + 8'($urandom_range(0, 9)));
        bq.push_back(LF);
        r = $urandom;
        res_q.push_back(r);
        exp_final = r;
        exp_lines++;
      end
      if ($urandom_range(0, 1) == 1) bq.push_back(8'h30 + 8'($urandom_range(0, 9)));
      ack_dly = $urandom_range(0, 3); res_dly = $urandom_range(0, 3); rel_dly = $urandom_range(0, 2);
      for (int i = 0; i < bq.size(); i++) send_byte(bq[i], i == bq.size() - 1);
      wait_end("rnd");
      chk("rnd_final", final_result, exp_final);
      chk("rnd_lines", 32'(lines_done), 32'(exp_lines));
      chk("rnd_done", 32'(done), 32'd1);
    end
    chk("valid_rise_while_ack", 32'(viol), 32'd0);

    // data_error while waiting for the result
    do_reset();
    ack_dly = 1; res_dly = 3; rel_dly = 0; mode = 3;
    base = clr_cnt;
    send_str("5\n", 1'b1);
    wait_end("t3");
    repeat (3) @(negedge clk);
    chk("t3_clear_cycles", 32'(clr_cnt - base), 32'd1);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_code", 32'(err_code), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    sr_any = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s_ready) sr_any = 1;
    end
    chk("t3_s_ready", 32'(sr_any), 32'd0);

    // Solver never acks
    do_reset();
    mode = 1;
    send_byte(8'h31, 1'b0);
    wait_end("t4");
    chk("t4_code", 32'(err_code), 32'd2);
    chk("t4_ack_to_cycles", 32'(t_err - t_valid), 32'(ACK_TO));
    chk("t4_dp_valid", 32'(dp_valid), 32'd0);

    // LF acked but result never arrives
    do_reset();
    mode = 0; ack_dly = 0; res_dly = 1;
    res_q.push_back(32'h1234);
    send_str("7\n", 1'b0);
    wait_ready("t5");
    mode = 2;
    send_str("3\n", 1'b0);
    wait_end("t5");
    chk("t5_code", 32'(err_code), 32'd3);
    chk("t5_res_to_cycles", 32'(t_err - t_ack), 32'(RES_TO));
    chk("t5_final", final_result, 32'h1234);
    chk("t5_lines", 32'(lines_done), 32'd1);

    // Reset pulse while in SEND
    do_reset();
    mode = 0; ack_dly = 1; res_dly = 1;
    res_q.push_back(32'h55);
    send_str("4\n", 1'b0);
    wait_ready("t6");
    chk("t6_pre_final", final_result, 32'h55);
    mode = 1;
    send_byte(8'h31, 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_pre_valid", 32'(dp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(dp_valid), 32'd0);
    chk("t6_rst_s_ready", 32'(s_ready), 32'd1);
    chk("t6_rst_final", final_result, 32'd0);
    chk("t6_rst_misc", {dp_data, dp_error_clear, done, err, err_code, lines_done}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    mode = 0;
    res_q.delete();
    res_q.push_back(32'h77);
    send_str("2\n", 1'b1);
    wait_end("t6");
    chk("t6_final", final_result, 32'h77);
    chk("t6_lines", 32'(lines_done), 32'd1);
    chk("t6_done", 32'(done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
